// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven instruction fetch with req/ack memory handshake and tagged FIFO; define INSTR_FETCH_BYPASS_EN for zero-latency empty-FIFO bypass
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int INSN_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              stop_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [INSN_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t state, state_next;
    logic [INSN_W-1:0] mem_insn [DEPTH];
    logic [ADDR_W-1:0] mem_pc [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [ADDR_W-1:0] addr_q;
    logic acked, byp, push, pop, has_room;

    assign acked = state == REQ && imem_ack;
`ifdef INSTR_FETCH_BYPASS_EN
    assign byp = acked && count == '0 && insn_ready && !flush;
`else
    assign byp = 1'b0;
`endif
    assign push = acked && !flush && !byp;
    assign pop = count != '0 && insn_ready && !flush;
    assign count_next = flush ? '0 : count + CW'(push) - CW'(pop);
    assign has_room = count_next < CW'(DEPTH);

    assign imem_req = state != IDLE;
    assign imem_addr = state == DROP ? addr_q : pc;
    assign stop_en = !(acked || flush);
    assign insn_valid = count != '0 || byp;
    assign insn = byp ? imem_rdata : mem_insn[rd_ptr];
    assign insn_pc = byp ? pc : mem_pc[rd_ptr];

    // next fetch state: keep one request outstanding only while space is guaranteed
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = (has_room && !flush) ? REQ : IDLE;
            REQ:  state_next = imem_ack ? ((has_room && !flush) ? REQ : IDLE) : (flush ? DROP : REQ);
            DROP: state_next = imem_ack ? IDLE : DROP;
            default: state_next = IDLE;
        endcase
    end

    // control registers: state, occupancy, pointers and the address held while dropping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            rd_ptr <= flush ? '0 : rd_ptr + PW'(pop);
            wr_ptr <= flush ? '0 : wr_ptr + PW'(push);
            addr_q <= state == REQ ? pc : addr_q;
        end
    end

    // FIFO storage: instruction tagged with the address it was fetched from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_insn[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (push) begin
            mem_insn[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= pc;
        end
    end
endmodule
